spi3w_adc_reg_responder: RTL and testbench

- 3-wire SPI responder (target) that emulates the ADC register port; it is the other end of the SEN/SCLK/SDIO interface used to configure the ADC.
- Oversamples SCLK/SEN/SDIO in the sys_clk domain, decodes write and read frames, and holds a small register file.
- Drives read data back on SDIO through an external IOBUF (sdio_o/sdio_oe_o).
- Used as the ADC model in the config-path bench and as a loopback target on the board.

---
 rtl/spi3w_adc_reg_responder_if.sv | 13 +
 rtl/spi3w_adc_reg_responder.sv | 192 +++++++++++++++++++
 tb/tb_spi3w_adc_reg_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spi3w_adc_reg_responder_if.sv
// SEN/SCLK/SDIO pin bundle between a 3-wire SPI initiator and the ADC
// register-port responder. Signal suffixes are from the responder's view.
`timescale 1ns/1ps
interface spi3w_adc_reg_responder_if;
  logic sclk_i;
  logic sen_i;
  logic sdio_i;
  logic sdio_o;
  logic sdio_oe_o;

  modport master (output sclk_i, sen_i, sdio_i, input sdio_o, sdio_oe_o);
  modport slave  (input sclk_i, sen_i, sdio_i, output sdio_o, sdio_oe_o);
endinterface

// File: rtl/spi3w_adc_reg_responder.sv
// 3-wire SPI responder emulating the ADC register port. Oversamples the
// SPI pins in sys_clk, decodes 24-bit write/read frames and holds a small
// register file; read data is driven back on SDIO through an external IOBUF.
`timescale 1ns/1ps
module spi3w_adc_reg_responder #(
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  spi3w_adc_reg_responder_if.slave       spi,
  input  logic                           adc_reset_i,
  output logic                           reg_wr_o,
  output logic                           reg_rd_o,
  output logic [13:0]                    reg_addr_o,
  output logic [7:0]                     reg_wdata_o,
  output logic                           frame_err_o
);

  localparam int DEPTH = 1 << REG_AW;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, HDR, WDATA, RDATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sen_sync_q, sdio_sync_q;
  logic                   sclk_last_q, sen_last_q;
  logic [1:0]             ares_sync_q;
  logic                   ares_last_q;

  state_t      state_q;
  logic [4:0]  bit_cnt_q;
  logic [14:0] sr_q;
  logic [13:0] addr_q;
  logic [6:0]  tx_q;
  logic        loaded_q;
  logic        sdio_q, sdio_oe_q;
  logic        reg_wr_q, reg_rd_q, frame_err_q;
  logic [13:0] reg_addr_q;
  logic [7:0]  reg_wdata_q;
  logic [7:0]  regs_q [DEPTH];

  logic        sclk_s, sen_s, sdio_s;
  logic        sclk_rise, sclk_fall, sen_rise, sen_fall, ares_rise;
  logic [15:0] hdr_d;
  logic [7:0]  wdata_d, rd_val_d;
  logic        mapped_d, wr_commit_d;
  logic [REG_AW-1:0] idx_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sen_s     = sen_sync_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_last_q;
  assign sclk_fall = ~sclk_s & sclk_last_q;
  assign sen_rise  = sen_s & ~sen_last_q;
  assign sen_fall  = ~sen_s & sen_last_q;
  assign ares_rise = ares_sync_q[1] & ~ares_last_q;

  // Decode helpers: next header word, write data, register index and mapping
  always_comb begin
    hdr_d       = {sr_q, sdio_s};
    wdata_d     = {sr_q[6:0], sdio_s};
    mapped_d    = (addr_q[13:REG_AW] == '0);
    idx_d       = addr_q[REG_AW-1:0];
    rd_val_d    = mapped_d ? regs_q[idx_d] : 8'h00;
    wr_commit_d = (state_q == WDATA) && sclk_rise && !sen_rise && (bit_cnt_q == 5'd23);
  end

  // Synchronizers and edge-detect flops; SEN resets low so a frame already
  // in progress at reset exit is never seen as a fresh falling edge
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sclk_sync_q <= '0;
      sen_sync_q  <= '0;
      sdio_sync_q <= '0;
      sclk_last_q <= 1'b0;
      sen_last_q  <= 1'b0;
      ares_sync_q <= '0;
      ares_last_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk_i};
      sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], spi.sen_i};
      sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], spi.sdio_i};
      sclk_last_q <= sclk_s;
      sen_last_q  <= sen_s;
      ares_sync_q <= {ares_sync_q[0], adc_reset_i};
      ares_last_q <= ares_sync_q[1];
    end
  end

  // Register file; a hard-reset edge beats a write committing in the same cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst || ares_rise) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
    end else if (wr_commit_d && mapped_d) begin
      regs_q[idx_d] <= wdata_d;
    end
  end

  // Frame FSM with registered SDIO drive and event outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= 5'd0;
      loaded_q    <= 1'b0;
      sdio_q      <= 1'b0;
      sdio_oe_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        WAIT_IDLE: if (sen_s) state_q <= IDLE;
        IDLE: begin
          bit_cnt_q <= 5'd0;
          loaded_q  <= 1'b0;
          if (sen_fall) state_q <= HDR;
        end
        HDR: begin
          if (sen_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else if (sclk_rise) begin
            sr_q      <= hdr_d[14:0];
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              addr_q   <= hdr_d[13:0];
              loaded_q <= 1'b0;
              state_q  <= hdr_d[15] ? RDATA : WDATA;
            end
          end
        end
        WDATA: begin
          if (sen_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else if (sclk_rise) begin
            sr_q      <= hdr_d[14:0];
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              reg_wr_q    <= 1'b1;
              reg_addr_q  <= addr_q;
              reg_wdata_q <= wdata_d;
              state_q     <= DONE;
            end
          end
        end
        RDATA: begin
          if (sen_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) state_q <= DONE;
          end else if (sclk_fall) begin
            if (!loaded_q) begin
              loaded_q   <= 1'b1;
              tx_q       <= rd_val_d[6:0];
              sdio_q     <= rd_val_d[7];
              sdio_oe_q  <= 1'b1;
              reg_rd_q   <= 1'b1;
              reg_addr_q <= addr_q;
            end else begin
              sdio_q <= tx_q[6];
              tx_q   <= {tx_q[5:0], 1'b0};
            end
          end
        end
        DONE: if (sen_rise) state_q <= IDLE;
        default: state_q <= WAIT_IDLE;
      endcase
      // SEN high always hands SDIO back to the initiator at once
      if (sen_rise) begin
        sdio_oe_q <= 1'b0;
        sdio_q    <= 1'b0;
      end
    end
  end

  assign spi.sdio_o    = sdio_q;
  assign spi.sdio_oe_o = sdio_oe_q;
  assign reg_wr_o      = reg_wr_q;
  assign reg_rd_o      = reg_rd_q;
  assign reg_addr_o    = reg_addr_q;
  assign reg_wdata_o   = reg_wdata_q;
  assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_spi3w_adc_reg_responder.sv
// Bench for the 3-wire SPI ADC register responder: directed scenarios plus
// randomized write/read traffic against a register-array reference model.
`timescale 1ns/1ps
module tb_spi3w_adc_reg_responder;

  localparam int REG_AW = 4;
  localparam int HP     = 80;   // SCLK half period: 16 sys_clk per SCLK period

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        adc_reset_i = 1'b0;
  logic        reg_wr_o, reg_rd_o, frame_err_o;
  logic [13:0] reg_addr_o;
  logic [7:0]  reg_wdata_o;

  spi3w_adc_reg_responder_if spi();

  spi3w_adc_reg_responder #(.REG_AW(REG_AW), .SYNC_STAGES(2), .RST_VAL(8'h00)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .spi         (spi.slave),
    .adc_reset_i (adc_reset_i),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .frame_err_o (frame_err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  int rs_wr, rs_rd, rs_err;
  logic [7:0] model_q [1 << REG_AW];

  // Pulse counters sampled away from the active edge
  always @(negedge sys_clk) begin
    if (reg_wr_o)    wr_cnt  <= wr_cnt + 1;
    if (reg_rd_o)    rd_cnt  <= rd_cnt + 1;
    if (frame_err_o) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [13:0] a);
    if (a < (1 << REG_AW)) return model_q[a[REG_AW-1:0]];
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < (1 << REG_AW); i++) model_q[i] = 8'h00;
  endtask

  // Drive one frame; abort_at stops before that rise, rst_at pulses sys_rst
  task automatic do_frame(input logic [23:0] fr, input int nbits, input int abort_at,
                          input int rst_at, output logic [7:0] rdata);
    bit rd, skip;
    rd = fr[23];
    skip = 1'b0;
    rdata = 8'h00;
    spi.sen_i = 1'b0;
    #(HP);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) break;
      if (i < 16 || (!rd && i < 24)) spi.sdio_i = fr[23-i];
      else                           spi.sdio_i = 1'($urandom);
      if (i == rst_at) begin
        @(negedge sys_clk) sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("rst_oe", 32'(spi.sdio_oe_o), 32'd0);
        rs_wr = wr_cnt; rs_rd = rd_cnt; rs_err = err_cnt;
        @(negedge sys_clk) sys_rst = 1'b0;
        skip = 1'b1;
      end
      #(HP);
      if (rd && !skip && i >= 15 && i < 24) begin
        chk("rd_oe", 32'(spi.sdio_oe_o), 32'(i >= 16));
        if (i >= 16) rdata[23-i] = spi.sdio_o;
      end
      spi.sclk_i = 1'b1;
      #(HP);
      spi.sclk_i = 1'b0;
    end
    #(HP);
    spi.sen_i = 1'b1;
    #(2*HP);
    if (!skip) chk("oe_release", 32'(spi.sdio_oe_o), 32'd0);
  endtask

  task automatic do_wr(input logic [13:0] a, input logic [7:0] d, input int nbits);
    int w0, e0;
    logic [7:0] dummy;
    w0 = wr_cnt; e0 = err_cnt;
    do_frame({1'b0, 1'($urandom), a, d}, nbits, -1, -1, dummy);
    chk("wr_pulse", 32'(wr_cnt - w0), 32'd1);
    chk("wr_addr", 32'(reg_addr_o), 32'(a));
    chk("wr_data", 32'(reg_wdata_o), 32'(d));
    chk("wr_noerr", 32'(err_cnt - e0), 32'd0);
    if (a < (1 << REG_AW)) model_q[a[REG_AW-1:0]] = d;
  endtask

  task automatic do_rd(input logic [13:0] a);
    int r0;
    logic [7:0] got;
    r0 = rd_cnt;
    do_frame({1'b1, 1'($urandom), a, 8'($urandom)}, 24, -1, -1, got);
    chk("rd_data", 32'(got), 32'(model_rd(a)));
    chk("rd_pulse", 32'(rd_cnt - r0), 32'd1);
    chk("rd_addr", 32'(reg_addr_o), 32'(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dummy;
    logic [13:0] a;
    int w0, e0, r0;
    spi.sclk_i = 1'b0;
    spi.sen_i  = 1'b1;
    spi.sdio_i = 1'b0;
    model_clear();
    repeat (5) @(negedge sys_clk);
    chk("rst_oe0", 32'(spi.sdio_oe_o), 32'd0);
    chk("rst_sdio0", 32'(spi.sdio_o), 32'd0);
    chk("rst_addr0", 32'(reg_addr_o), 32'd0);
    chk("rst_wdata0", 32'(reg_wdata_o), 32'd0);
    chk("rst_pulses0", 32'({reg_wr_o, reg_rd_o, frame_err_o}), 32'd0);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);

    // Basic write then read-back
    do_wr(14'h0005, 8'hA5, 24);
    do_rd(14'h0005);

    // Unmapped read and write
    do_rd(14'h0100);
    do_wr(14'h0100, 8'h3C, 24);
    do_rd(14'h0000);

    // Aborted write frame
    w0 = wr_cnt; e0 = err_cnt;
    do_frame({2'b00, 14'h0002, 8'h77}, 24, 12, -1, dummy);
    chk("abort_err", 32'(err_cnt - e0), 32'd1);
    chk("abort_nowr", 32'(wr_cnt - w0), 32'd0);
    do_wr(14'h0002, 8'h11, 24);
    do_rd(14'h0002);

    // Hard reset line clears the register file
    do_wr(14'h0003, 8'hFF, 24);
    adc_reset_i = 1'b1;
    #(6*HP);
    adc_reset_i = 1'b0;
    #(2*HP);
    model_clear();
    do_rd(14'h0003);
    do_rd(14'h0002);

    // sys_rst during the 4th read data bit
    do_wr(14'h0006, 8'hC7, 24);
    do_frame({2'b10, 14'h0006, 8'h00}, 24, -1, 19, dummy);
    chk("rst_nowr", 32'(wr_cnt - rs_wr), 32'd0);
    chk("rst_nord", 32'(rd_cnt - rs_rd), 32'd0);
    chk("rst_noerr", 32'(err_cnt - rs_err), 32'd0);
    chk("rst_addr", 32'(reg_addr_o), 32'd0);
    model_clear();
    do_rd(14'h0006);
    do_wr(14'h0006, 8'h5A, 24);
    do_rd(14'h0006);

    // Back-to-back writes and an over-long frame
    do_wr(14'h0007, 8'h5C, 24);
    do_wr(14'h0008, 8'hC3, 24);
    do_wr(14'h0009, 8'h96, 26);
    do_rd(14'h0007);
    do_rd(14'h0008);
    do_rd(14'h0009);

    // Randomized traffic, some to unmapped addresses
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) a = 14'($urandom);
      else                           a = 14'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_wr(a, 8'($urandom), 24 + $urandom_range(0, 2));
      else                           do_rd(a);
    end
    r0 = rd_cnt;
    chk("final_oe", 32'(spi.sdio_oe_o), 32'd0);
    chk("final_quiet", 32'(rd_cnt - r0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
